// File: rtl/key_matrix_scan_pkg.sv
// Shared types for the key matrix scanner: scan FSM state encoding.
package key_matrix_scan_pkg;

  typedef enum logic [1:0] {
    ST_DWELL = 2'd0,
    ST_EVAL  = 2'd1,
    ST_EMIT  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/binary_decoder.sv
// Binary index to one-hot decoder.
module binary_decoder #(
  parameter int OUTPUTS = 4,
  parameter int WIDTH   = 2
) (
  input  logic [WIDTH-1:0]   i_sel,
  output logic [OUTPUTS-1:0] o_onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < OUTPUTS; gi++) begin : g_out
      assign o_onehot[gi] = (i_sel == WIDTH'(gi));
    end
  endgenerate

endmodule

// File: rtl/key_debounce_cell.sv
// One key's debouncer: a stable bit plus a count of consecutive samples that disagree with it.
module key_debounce_cell #(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int DEBOUNCE_WIDTH = 3
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_sample,
  output logic o_stable,
  output logic o_flip
);

  logic                      r_stable;
  logic [DEBOUNCE_WIDTH-1:0] r_cnt;
  logic [DEBOUNCE_WIDTH-1:0] w_cnt_inc;
  logic                      w_differ;

  assign w_differ  = (i_sample != r_stable);
  assign w_cnt_inc = r_cnt + DEBOUNCE_WIDTH'(1);
  // Flip is combinational so the scanner can launch the event on the same evaluation cycle.
  assign o_flip    = i_en && w_differ && (w_cnt_inc == DEBOUNCE_WIDTH'(DEBOUNCE_SCANS));
  assign o_stable  = r_stable;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (i_en) begin
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (o_flip) begin
        r_stable <= i_sample;
        r_cnt    <= '0;
      end else begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

endmodule

// File: rtl/key_matrix_scan.sv
// Row/column key matrix scanner: drives rows one-hot, synchronises and debounces columns,
// and reports press/release events over a valid/ready handshake.
import key_matrix_scan_pkg::*;

module key_matrix_scan #(
  parameter int NUM_ROWS          = 4,
  parameter int NUM_ROWS_WIDTH    = 2,
  parameter int NUM_COLS          = 4,
  parameter int NUM_COLS_WIDTH    = 2,
  parameter int CLOCK_DELAY       = 1000,
  parameter int CLOCK_DELAY_WIDTH = 10,
  parameter int DEBOUNCE_SCANS    = 4,
  parameter int DEBOUNCE_WIDTH    = 3
) (
  input  logic                         clk,
  input  logic                         i_rst,
  input  logic [NUM_COLS-1:0]          i_cols,
  input  logic                         i_evt_ready,
  output logic [NUM_ROWS-1:0]          o_rows,
  output logic                         o_evt_valid,
  output logic                         o_evt_press,
  output logic [NUM_ROWS_WIDTH-1:0]    o_evt_row,
  output logic [NUM_COLS_WIDTH-1:0]    o_evt_col,
  output logic [NUM_ROWS*NUM_COLS-1:0] o_keys
);

  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
  localparam logic [CLOCK_DELAY_WIDTH-1:0] DWELL_LAST = CLOCK_DELAY_WIDTH'(CLOCK_DELAY - 1);

  scan_state_t                   r_state;
  logic [CLOCK_DELAY_WIDTH-1:0]  r_dwell_cnt;
  logic [NUM_ROWS_WIDTH-1:0]     r_row;
  logic [NUM_COLS_WIDTH-1:0]     r_col;
  logic [NUM_COLS-1:0]           r_sync1;
  logic [NUM_COLS-1:0]           r_sync2;
  logic [NUM_COLS-1:0]           r_sample;
  logic                          r_evt_valid;
  logic                          r_evt_press;
  logic [NUM_ROWS_WIDTH-1:0]     r_evt_row;
  logic [NUM_COLS_WIDTH-1:0]     r_evt_col;

  logic [NUM_KEYS-1:0]           w_eval_en;
  logic [NUM_KEYS-1:0]           w_flip;
  logic                          w_any_flip;
  logic                          w_sample_bit;
  logic                          w_last_col;
  logic [NUM_ROWS_WIDTH-1:0]     w_row_next;

  assign w_sample_bit = r_sample[r_col];
  assign w_any_flip   = |w_flip;
  assign w_last_col   = (r_col == NUM_COLS_WIDTH'(NUM_COLS - 1));
  assign w_row_next   = (r_row == NUM_ROWS_WIDTH'(NUM_ROWS - 1)) ? '0
                                                                 : r_row + NUM_ROWS_WIDTH'(1);

  binary_decoder #(
    .OUTPUTS (NUM_ROWS),
    .WIDTH   (NUM_ROWS_WIDTH)
  ) u_row_decoder (
    .i_sel    (r_row),
    .o_onehot (o_rows)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      localparam int KEY_ROW = gi / NUM_COLS;
      localparam int KEY_COL = gi % NUM_COLS;

      // Only the key under the evaluation cursor may update its debouncer this cycle.
      assign w_eval_en[gi] = (r_state == ST_EVAL) &&
                             (r_row == NUM_ROWS_WIDTH'(KEY_ROW)) &&
                             (r_col == NUM_COLS_WIDTH'(KEY_COL));

      key_debounce_cell #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
        .DEBOUNCE_WIDTH (DEBOUNCE_WIDTH)
      ) u_cell (
        .clk      (clk),
        .i_rst    (i_rst),
        .i_en     (w_eval_en[gi]),
        .i_sample (w_sample_bit),
        .o_stable (o_keys[gi]),
        .o_flip   (w_flip[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state     <= ST_DWELL;
      r_dwell_cnt <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_sample    <= '0;
      r_evt_valid <= 1'b0;
      r_evt_press <= 1'b0;
      r_evt_row   <= '0;
      r_evt_col   <= '0;
    end else begin
      r_sync1 <= i_cols;
      r_sync2 <= r_sync1;
      case (r_state)
        ST_DWELL: begin
          if (r_dwell_cnt == DWELL_LAST) begin
            r_dwell_cnt <= '0;
            r_sample    <= r_sync2;
            r_col       <= '0;
            r_state     <= ST_EVAL;
          end else begin
            r_dwell_cnt <= r_dwell_cnt + CLOCK_DELAY_WIDTH'(1);
          end
        end
        ST_EVAL: begin
          if (w_any_flip) begin
            r_evt_valid <= 1'b1;
            r_evt_press <= w_sample_bit;
            r_evt_row   <= r_row;
            r_evt_col   <= r_col;
            r_state     <= ST_EMIT;
          end else if (w_last_col) begin
            r_col   <= '0;
            r_row   <= w_row_next;
            r_state <= ST_DWELL;
          end else begin
            r_col <= r_col + NUM_COLS_WIDTH'(1);
          end
        end
        ST_EMIT: begin
          // The whole scan stalls here until the consumer takes the event.
          if (i_evt_ready) begin
            r_evt_valid <= 1'b0;
            if (w_last_col) begin
              r_col   <= '0;
              r_row   <= w_row_next;
              r_state <= ST_DWELL;
            end else begin
              r_col   <= r_col + NUM_COLS_WIDTH'(1);
              r_state <= ST_EVAL;
            end
          end
        end
        default: r_state <= ST_DWELL;
      endcase
    end
  end

  assign o_evt_valid = r_evt_valid;
  assign o_evt_press = r_evt_press;
  assign o_evt_row   = r_evt_row;
  assign o_evt_col   = r_evt_col;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Bench for key_matrix_scan: cycle-level behavioural model plus directed and random key activity.
module tb_key_matrix_scan;

  localparam int NR = 4;
  localparam int NC = 4;
  localparam int CD = 4;
  localparam int DB = 3;
  localparam int NK = NR * NC;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_evt_ready;
  logic [NC-1:0] i_cols;
  logic [NR-1:0] o_rows;
  logic          o_evt_valid;
  logic          o_evt_press;
  logic [1:0]    o_evt_row;
  logic [1:0]    o_evt_col;
  logic [NK-1:0] o_keys;

  logic [NK-1:0] phys;

  always #5 clk = ~clk;

  key_matrix_scan #(
    .NUM_ROWS (NR), .NUM_ROWS_WIDTH (2), .NUM_COLS (NC), .NUM_COLS_WIDTH (2),
    .CLOCK_DELAY (CD), .CLOCK_DELAY_WIDTH (2), .DEBOUNCE_SCANS (DB), .DEBOUNCE_WIDTH (2)
  ) dut (
    .clk (clk), .i_rst (i_rst), .i_cols (i_cols), .i_evt_ready (i_evt_ready),
    .o_rows (o_rows), .o_evt_valid (o_evt_valid), .o_evt_press (o_evt_press),
    .o_evt_row (o_evt_row), .o_evt_col (o_evt_col), .o_keys (o_keys)
  );

  // Physical matrix: a closed key pulls its column when its row is driven.
  always_comb begin
    i_cols = '0;
    for (int r = 0; r < NR; r++)
      if (o_rows[r]) i_cols = i_cols | phys[r*NC +: NC];
  end

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct { bit press; int row; int col; } ev_t;

  int            m_row, m_pos;
  bit [NC-1:0]   m_sync1, m_sync2, m_sample;
  bit [NK-1:0]   m_keys;
  int            m_cnt[NK];
  bit            m_pend, m_ev_press, m_started;
  int            m_ev_row, m_ev_col;
  ev_t           m_log[$];

  // Position within a row period: 0..CD-1 dwelling, CD..CD+NC-1 evaluating column pos-CD.
  function automatic void model_advance();
    m_pos++;
    if (m_pos == CD + NC) begin
      m_pos = 0;
      m_row = (m_row + 1) % NR;
    end
  endfunction

  function automatic void model_step(bit rst, bit rdy, bit [NK-1:0] ph);
    bit [NC-1:0] cols_now;
    int col, k;
    if (rst) begin
      m_row = 0; m_pos = 0; m_sync1 = '0; m_sync2 = '0; m_sample = '0;
      m_keys = '0; m_pend = 0; m_started = 1;
      for (int i = 0; i < NK; i++) m_cnt[i] = 0;
      return;
    end
    cols_now = ph[m_row*NC +: NC];
    if (m_pend) begin
      if (rdy) begin
        m_pend = 0;
        m_log.push_back('{m_ev_press, m_ev_row, m_ev_col});
        model_advance();
      end
    end else if (m_pos < CD) begin
      if (m_pos == CD - 1) m_sample = m_sync2;
      m_pos++;
    end else begin
      col = m_pos - CD;
      k = m_row * NC + col;
      if (m_sample[col] != m_keys[k]) begin
        if (m_cnt[k] + 1 == DB) begin
          m_keys[k] = m_sample[col];
          m_cnt[k] = 0;
          m_pend = 1;
          m_ev_press = m_sample[col];
          m_ev_row = m_row;
          m_ev_col = col;
        end else begin
          m_cnt[k]++;
        end
      end else begin
        m_cnt[k] = 0;
      end
      if (!m_pend) model_advance();
    end
    m_sync2 = m_sync1;
    m_sync1 = cols_now;
  endfunction

  // Model steps on each rising edge; DUT compared against it on the falling edge.
  initial begin
    m_started = 0;
    forever begin
      @(posedge clk);
      model_step(i_rst, i_evt_ready, phys);
      @(negedge clk);
      if (m_started) begin
        check("rows", o_rows, 32'(1 << m_row));
        check("keys", o_keys, m_keys);
        check("evt_valid", o_evt_valid, m_pend);
        if (m_pend) begin
          check("evt_press", o_evt_press, m_ev_press);
          check("evt_row", o_evt_row, m_ev_row);
          check("evt_col", o_evt_col, m_ev_col);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_valid(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_evt_valid !== 1'b1 && n < budget);
    check("wait_valid", o_evt_valid, 1);
  endtask

  task automatic wait_rows(input logic [NR-1:0] val, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_rows !== val && n < budget);
    check("wait_rows", o_rows, val);
  endtask

  initial begin
    int n;
    phys = '0;
    i_evt_ready = 1'b1;
    i_rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rows", o_rows, 4'b0001);
    check("rst_valid", o_evt_valid, 0);
    check("rst_keys", o_keys, 0);
    check("rst_fields", {o_evt_press, o_evt_row, o_evt_col}, 0);
    i_rst = 1'b0;

    // Idle scan: each row dwells CD+NC cycles.
    repeat (8) @(negedge clk);
    check("t1_row1", o_rows, 4'b0010);
    repeat (24) @(negedge clk);
    check("t1_row0_again", o_rows, 4'b0001);
    check("t1_valid", o_evt_valid, 0);

    // Single held key.
    phys[9] = 1'b1;
    wait_valid(200);
    check("t2_press", o_evt_press, 1);
    check("t2_row", o_evt_row, 2);
    check("t2_col", o_evt_col, 1);
    check("t2_key9", o_keys[9], 1);

    // Bounce shorter than the debounce window.
    wait_rows(4'b0010, 100);
    n = m_log.size();
    phys[0] = 1'b1;
    repeat (64) @(negedge clk);
    phys[0] = 1'b0;
    repeat (64) @(negedge clk);
    check("t3_no_event", m_log.size(), n);
    check("t3_keys", o_keys, 16'h0200);

    // Backpressure freezes the scan.
    i_evt_ready = 1'b0;
    phys[15] = 1'b1;
    wait_valid(200);
    for (int i = 0; i < 20; i++) begin
      check("t4_valid", o_evt_valid, 1);
      check("t4_fields", {o_evt_press, o_evt_row, o_evt_col}, 5'b1_11_11);
      check("t4_rows", o_rows, 4'b1000);
      @(negedge clk);
    end
    i_evt_ready = 1'b1;
    @(negedge clk);
    check("t4_release", o_evt_valid, 0);

    // Two keys in one row: ascending column order.
    n = m_log.size();
    phys[4] = 1'b1;
    phys[7] = 1'b1;
    repeat (160) @(negedge clk);
    check("t5_count", m_log.size(), n + 2);
    if (m_log.size() >= n + 2) begin
      check("t5_ev0", {m_log[n].press, 2'(m_log[n].row), 2'(m_log[n].col)}, 5'b1_01_00);
      check("t5_ev1", {m_log[n+1].press, 2'(m_log[n+1].row), 2'(m_log[n+1].col)}, 5'b1_01_11);
    end
    check("t5_keys", {o_keys[7], o_keys[4]}, 2'b11);

    // Release event, then reset during a pending event.
    phys[9] = 1'b0;
    wait_valid(200);
    check("t6_press", o_evt_press, 0);
    check("t6_pos", {o_evt_row, o_evt_col}, 4'b10_01);
    @(negedge clk);
    i_evt_ready = 1'b0;
    phys[9] = 1'b1;
    wait_valid(200);
    i_rst = 1'b1;
    @(negedge clk);
    check("t6_rst_valid", o_evt_valid, 0);
    check("t6_rst_keys", o_keys, 0);
    check("t6_rst_rows", o_rows, 4'b0001);
    i_rst = 1'b0;
    i_evt_ready = 1'b1;

    // Random key activity, random backpressure, rare resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        n = $urandom_range(0, NK - 1);
        phys[n] = ~phys[n];
      end
      i_evt_ready = ($urandom_range(0, 9) < 7);
      i_rst = ($urandom_range(0, 1999) == 0);
    end
    i_rst = 1'b0;
    i_evt_ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
